cursor_ctrl: RTL and testbench

//   Sequences the 6-bit cursor/column counter for the editor datapath.

---
 rtl/cursor_ctrl_if.sv | 13 +
 rtl/cursor_ctrl.sv | 174 +++++++++++++++++
 tb/tb_cursor_ctrl.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cursor_ctrl_if.sv
// Command handshake from the keyboard decoder into cursor_ctrl; the command is
// held by the requester until cmd_valid and cmd_ready are both high on a clock edge.
interface cursor_ctrl_if #(
  parameter int WIDTH = 6
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_arg;

  modport master (output cmd_valid, cmd_op, cmd_arg, input  cmd_ready);
  modport slave  (input  cmd_valid, cmd_op, cmd_arg, output cmd_ready);
endinterface

// File: rtl/cursor_ctrl.sv
// Turns one cursor command into registered, clamped counter strobes; step k strobes in cycle k,
// done one cycle after the last strobe. cmd_ready is high only in IDLE, so commands wait while busy.
module cursor_ctrl #(
  parameter int WIDTH = 6
) (
  input  logic             clk_i,
  input  logic             clr_n_i,
  cursor_ctrl_if.slave     cmd,
  input  logic [WIDTH-1:0] line_len_i,
  input  logic [WIDTH-1:0] q_in_i,
  output logic             cnt_inc_o,
  output logic             cnt_dec_o,
  output logic             cnt_par_o,
  output logic [WIDTH-1:0] cnt_load_o,
  output logic             cnt_clr_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             sat_o,
  output logic             err_o
);

  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_RIGHT = 3'b001;
  localparam logic [2:0] OP_LEFT  = 3'b010;
  localparam logic [2:0] OP_HOME  = 3'b011;
  localparam logic [2:0] OP_END   = 3'b100;
  localparam logic [2:0] OP_GOTO  = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE, S_STEP_R, S_STEP_L, S_LOAD, S_CLEAR, S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pos_q, pos_d;
  logic [WIDTH-1:0] lim_q, lim_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] load_q, load_d;
  logic             sat_q, sat_d;
  logic             err_q, err_d;
  logic             inc_q, inc_d;
  logic             dec_q, dec_d;
  logic             par_q, clr_q, done_q;

  logic             accept;
  logic             want_r, want_l;
  logic [WIDTH-1:0] ev_pos, ev_lim, ev_rem;

  assign accept = (state_q == S_IDLE) && cmd.cmd_valid;
  assign want_r = accept ? (cmd.cmd_op == OP_RIGHT) : (state_q == S_STEP_R);
  assign want_l = accept ? (cmd.cmd_op == OP_LEFT)  : (state_q == S_STEP_L);

  // The first step is decided at accept from the live inputs; pos/rem then hold the
  // values after the strobe currently on the wire, so strobe k lands in cycle k.
  assign ev_pos = accept ? q_in_i       : pos_q;
  assign ev_lim = accept ? line_len_i   : lim_q;
  assign ev_rem = accept ? cmd.cmd_arg  : rem_q;

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    lim_d   = lim_q;
    rem_d   = rem_q;
    sat_d   = sat_q;
    err_d   = err_q;
    inc_d   = 1'b0;
    dec_d   = 1'b0;
    load_d  = '0;

    if (accept) begin
      sat_d = 1'b0;
      err_d = 1'b0;
      lim_d = line_len_i;
    end

    if (want_r) begin
      if (ev_rem == '0) begin
        state_d = S_DONE;
      end else if (ev_pos >= ev_lim) begin
        sat_d   = 1'b1;
        state_d = S_DONE;
      end else begin
        inc_d   = 1'b1;
        pos_d   = ev_pos + 1'b1;
        rem_d   = ev_rem - 1'b1;
        state_d = S_STEP_R;
      end
    end else if (want_l) begin
      if (ev_rem == '0) begin
        state_d = S_DONE;
      end else if (ev_pos == '0) begin
        sat_d   = 1'b1;
        state_d = S_DONE;
      end else begin
        dec_d   = 1'b1;
        pos_d   = ev_pos - 1'b1;
        rem_d   = ev_rem - 1'b1;
        state_d = S_STEP_L;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            case (cmd.cmd_op)
              OP_NOP:  state_d = S_DONE;
              OP_HOME: state_d = S_CLEAR;
              OP_END: begin
                state_d = S_LOAD;
                load_d  = line_len_i;
              end
              OP_GOTO: begin
                state_d = S_LOAD;
                if (cmd.cmd_arg > line_len_i) begin
                  load_d = line_len_i;
                  sat_d  = 1'b1;
                end else begin
                  load_d = cmd.cmd_arg;
                end
              end
              default: begin
                err_d   = 1'b1;
                state_d = S_DONE;
              end
            endcase
          end
        end
        S_LOAD, S_CLEAR: state_d = S_DONE;
        S_DONE:          state_d = S_IDLE;
        default:         state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge clr_n_i) begin
    if (!clr_n_i) begin
      state_q <= S_IDLE;
      pos_q   <= '0;
      lim_q   <= '0;
      rem_q   <= '0;
      load_q  <= '0;
      sat_q   <= 1'b0;
      err_q   <= 1'b0;
      inc_q   <= 1'b0;
      dec_q   <= 1'b0;
      par_q   <= 1'b0;
      clr_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      lim_q   <= lim_d;
      rem_q   <= rem_d;
      load_q  <= load_d;
      sat_q   <= sat_d;
      err_q   <= err_d;
      inc_q   <= inc_d;
      dec_q   <= dec_d;
      par_q   <= (state_d == S_LOAD);
      clr_q   <= (state_d == S_CLEAR);
      done_q  <= (state_d == S_DONE);
    end
  end

  assign cmd.cmd_ready = (state_q == S_IDLE);
  assign busy_o        = (state_q != S_IDLE);
  assign cnt_inc_o     = inc_q;
  assign cnt_dec_o     = dec_q;
  assign cnt_par_o     = par_q;
  assign cnt_load_o    = load_q;
  assign cnt_clr_o     = clr_q;
  assign done_o        = done_q;
  assign sat_o         = done_q & sat_q;
  assign err_o         = done_q & err_q;

endmodule

// File: tb/tb_cursor_ctrl.sv
// Bench for cursor_ctrl: a command-level model predicts every output cycle, and literal
// expectations pin the documented cursor scenarios, reset and busy-hold behaviour.
module tb_cursor_ctrl;
  localparam int W = 6;

  typedef struct packed {
    logic         inc, dec, par, clr, busy, done, sat, err, rdy;
    logic [W-1:0] load;
    logic [W-1:0] col;
  } exp_t;

  logic         clk      = 1'b0;
  logic         clr_n    = 1'b0;
  logic [W-1:0] line_len = '0;
  logic [W-1:0] q        = '0;
  logic         cnt_inc, cnt_dec, cnt_par, cnt_clr, busy, done, sat, err;
  logic [W-1:0] cnt_load;
  int           n_chk  = 0;
  int           n_pass = 0;
  exp_t         exp_cur = '{rdy: 1'b1, default: '0};
  exp_t         tq[$];

  cursor_ctrl_if #(.WIDTH(W)) cif ();

  cursor_ctrl #(.WIDTH(W)) dut (
    .clk_i     (clk),
    .clr_n_i   (clr_n),
    .cmd       (cif),
    .line_len_i(line_len),
    .q_in_i    (q),
    .cnt_inc_o (cnt_inc),
    .cnt_dec_o (cnt_dec),
    .cnt_par_o (cnt_par),
    .cnt_load_o(cnt_load),
    .cnt_clr_o (cnt_clr),
    .busy_o    (busy),
    .done_o    (done),
    .sat_o     (sat),
    .err_o     (err)
  );

  always #5 clk = ~clk;

  // External column counter; not reset by this block.
  always @(posedge clk) begin
    if (cnt_clr)      q <= '0;
    else if (cnt_par) q <= cnt_load;
    else if (cnt_inc) q <= q + 1'b1;
    else if (cnt_dec) q <= q - 1'b1;
  end

  function automatic exp_t idle_vec(input logic [W-1:0] c);
    exp_t v = '0;
    v.rdy = 1'b1;
    v.col = c;
    return v;
  endfunction

  function automatic exp_t busy_vec(input int c);
    exp_t v = '0;
    v.busy = 1'b1;
    v.col  = W'(c);
    return v;
  endfunction

  // Whole-command prediction: number of steps and final column from plain arithmetic.
  task automatic build(input logic [2:0] op, input int arg, input int lim, input int c0);
    exp_t v;
    int   n, tgt;
    case (op)
      3'd1: begin
        n = (c0 >= lim) ? 0 : ((arg < lim - c0) ? arg : lim - c0);
        for (int k = 0; k < n; k++) begin
          v = busy_vec(c0 + k); v.inc = 1'b1; tq.push_back(v);
        end
        v = busy_vec(c0 + n); v.done = 1'b1; v.sat = (n < arg); tq.push_back(v);
      end
      3'd2: begin
        n = (arg < c0) ? arg : c0;
        for (int k = 0; k < n; k++) begin
          v = busy_vec(c0 - k); v.dec = 1'b1; tq.push_back(v);
        end
        v = busy_vec(c0 - n); v.done = 1'b1; v.sat = (n < arg); tq.push_back(v);
      end
      3'd3: begin
        v = busy_vec(c0); v.clr = 1'b1; tq.push_back(v);
        v = busy_vec(0);  v.done = 1'b1; tq.push_back(v);
      end
      3'd4, 3'd5: begin
        tgt = (op == 3'd4 || arg > lim) ? lim : arg;
        v = busy_vec(c0); v.par = 1'b1; v.load = W'(tgt); tq.push_back(v);
        v = busy_vec(tgt); v.done = 1'b1; v.sat = (op == 3'd5) && (arg > lim); tq.push_back(v);
      end
      3'd0: begin
        v = busy_vec(c0); v.done = 1'b1; tq.push_back(v);
      end
      default: begin
        v = busy_vec(c0); v.done = 1'b1; v.err = 1'b1; tq.push_back(v);
      end
    endcase
  endtask

  always @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      tq.delete();
      exp_cur <= idle_vec(exp_cur.col);
    end else begin
      if (exp_cur.rdy && cif.cmd_valid)
        build(cif.cmd_op, int'(cif.cmd_arg), int'(line_len), int'(exp_cur.col));
      if (tq.size() > 0) exp_cur <= tq.pop_front();
      else               exp_cur <= idle_vec(exp_cur.col);
    end
  end

  always @(negedge clk) begin
    exp_t act;
    act      = '0;
    act.inc  = cnt_inc;
    act.dec  = cnt_dec;
    act.par  = cnt_par;
    act.clr  = cnt_clr;
    act.busy = busy;
    act.done = done;
    act.sat  = sat & exp_cur.done;
    act.err  = err & exp_cur.done;
    act.rdy  = cif.cmd_ready;
    act.load = cnt_load;
    act.col  = q;
    n_chk++;
    if (act === exp_cur) n_pass++;
    else $display("FAIL cycle_outputs t=%0t got=%h expected=%h", $time, act, exp_cur);
  end

  task automatic chk(input string name, input int act, input int expv);
    n_chk++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, expv);
  endtask

  task automatic wait_ready();
    int c = 0;
    while (!cif.cmd_ready && c < 100) begin
      @(negedge clk);
      c++;
    end
    chk("accept_wait", int'(cif.cmd_ready), 1);
  endtask

  task automatic run_cmd(input logic [2:0] op, input logic [W-1:0] arg, input logic [W-1:0] len,
                         output int ni, output int nd, output int np, output int nc,
                         output int dn, output logic s, output logic e, output logic [W-1:0] ld);
    ni = 0; nd = 0; np = 0; nc = 0; dn = -1; s = 1'b0; e = 1'b0; ld = '0;
    @(negedge clk);
    cif.cmd_op = op; cif.cmd_arg = arg; line_len = len; cif.cmd_valid = 1'b1;
    wait_ready();
    @(negedge clk);
    cif.cmd_valid = 1'b0;
    cif.cmd_op    = 3'($urandom_range(0, 7));
    line_len      = W'($urandom_range(0, 63));
    for (int k = 1; k <= 70 && dn < 0; k++) begin
      ni += int'(cnt_inc); nd += int'(cnt_dec); np += int'(cnt_par); nc += int'(cnt_clr);
      if (cnt_par) ld = cnt_load;
      if (done) begin dn = k; s = sat; e = err; end
      if (dn < 0) @(negedge clk);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int ni, nd, np, nc, dn, r, gap;
    logic s, e;
    logic [W-1:0] ld;
    logic hclr[1:4], hdone[1:4], herr[1:4], hrdy[1:4];

    cif.cmd_valid = 1'b0; cif.cmd_op = '0; cif.cmd_arg = '0;
    #12;
    chk("reset_ready", int'(cif.cmd_ready), 1);
    chk("reset_outputs", int'({cnt_inc, cnt_dec, cnt_par, cnt_clr, busy, done, sat, err, cnt_load}), 0);
    @(negedge clk); #2 clr_n = 1'b1;

    run_cmd(3'd5, 6'd10, 6'd63, ni, nd, np, nc, dn, s, e, ld);
    chk("goto10_load", int'(ld), 10);
    chk("goto10_done", dn, 2);
    run_cmd(3'd1, 6'd5, 6'd40, ni, nd, np, nc, dn, s, e, ld);
    chk("right5_incs", ni, 5);
    chk("right5_done", dn, 6);
    chk("right5_sat", int'(s), 0);
    chk("right5_col", int'(q), 15);

    run_cmd(3'd5, 6'd38, 6'd63, ni, nd, np, nc, dn, s, e, ld);
    run_cmd(3'd1, 6'd5, 6'd40, ni, nd, np, nc, dn, s, e, ld);
    chk("right_clamp_incs", ni, 2);
    chk("right_clamp_done", dn, 3);
    chk("right_clamp_sat", int'(s), 1);
    chk("right_clamp_col", int'(q), 40);

    run_cmd(3'd5, 6'd3, 6'd63, ni, nd, np, nc, dn, s, e, ld);
    run_cmd(3'd2, 6'd10, 6'd40, ni, nd, np, nc, dn, s, e, ld);
    chk("left_clamp_decs", nd, 3);
    chk("left_clamp_sat", int'(s), 1);
    chk("left_clamp_col", int'(q), 0);

    run_cmd(3'd5, 6'd50, 6'd40, ni, nd, np, nc, dn, s, e, ld);
    chk("goto50_par", np, 1);
    chk("goto50_load", int'(ld), 40);
    chk("goto50_done", dn, 2);
    chk("goto50_sat", int'(s), 1);
    run_cmd(3'd4, 6'd0, 6'd63, ni, nd, np, nc, dn, s, e, ld);
    chk("end_load", int'(ld), 63);
    chk("end_sat", int'(s), 0);
    chk("end_col", int'(q), 63);

    run_cmd(3'd3, 6'd0, 6'd40, ni, nd, np, nc, dn, s, e, ld);
    chk("home_clr", nc, 1);
    chk("home_done", dn, 2);
    chk("home_col", int'(q), 0);
    run_cmd(3'b110, 6'd7, 6'd40, ni, nd, np, nc, dn, s, e, ld);
    chk("illegal_strobes", ni + nd + np + nc, 0);
    chk("illegal_done", dn, 1);
    chk("illegal_err", int'(e), 1);

    // HOME followed by an illegal op that is presented while HOME is still busy.
    @(negedge clk);
    cif.cmd_op = 3'd3; cif.cmd_arg = '0; line_len = 6'd20; cif.cmd_valid = 1'b1;
    wait_ready();
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      hclr[k] = cnt_clr; hdone[k] = done; herr[k] = err; hrdy[k] = cif.cmd_ready;
      if (k == 1) cif.cmd_op = 3'b110;
      if (k == 4) cif.cmd_valid = 1'b0;
    end
    chk("hold_clr_c1", int'(hclr[1]), 1);
    chk("hold_rdy_c1", int'(hrdy[1]), 0);
    chk("hold_done_c2", int'(hdone[2]), 1);
    chk("hold_err_c2", int'(herr[2]), 0);
    chk("hold_rdy_c2", int'(hrdy[2]), 0);
    chk("hold_rdy_c3", int'(hrdy[3]), 1);
    chk("hold_done_c4", int'(hdone[4]), 1);
    chk("hold_err_c4", int'(herr[4]), 1);

    // Reset in the middle of a long RIGHT move.
    @(negedge clk);
    cif.cmd_op = 3'd1; cif.cmd_arg = 6'd40; line_len = 6'd63; cif.cmd_valid = 1'b1;
    wait_ready();
    @(negedge clk);
    cif.cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 clr_n = 1'b0;
    #1;
    chk("midrst_ready", int'(cif.cmd_ready), 1);
    chk("midrst_outputs", int'({cnt_inc, cnt_dec, cnt_par, cnt_clr, busy, done, sat, err, cnt_load}), 0);
    @(negedge clk);
    @(negedge clk);
    chk("midrst_col_held", int'(q), 3);
    #2 clr_n = 1'b1;
    run_cmd(3'd1, 6'd5, 6'd40, ni, nd, np, nc, dn, s, e, ld);
    chk("after_rst_incs", ni, 5);
    chk("after_rst_done", dn, 6);
    chk("after_rst_col", int'(q), 8);

    @(negedge clk);
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 15);
      cif.cmd_op  = (r < 5) ? 3'd1 : (r < 10) ? 3'd2 : 3'($urandom_range(0, 7));
      cif.cmd_arg = ($urandom_range(0, 1) == 1) ? W'($urandom_range(0, 8)) : W'($urandom_range(0, 63));
      r = $urandom_range(0, 7);
      line_len = (r == 0) ? 6'd63 : (r == 1) ? 6'd0 : W'($urandom_range(0, 63));
      cif.cmd_valid = 1'b1;
      wait_ready();
      @(negedge clk);
      line_len = W'($urandom_range(0, 63));
      gap = $urandom_range(0, 2);
      if (gap > 0) begin
        cif.cmd_valid = 1'b0;
        repeat (gap) @(negedge clk);
      end
    end
    cif.cmd_valid = 1'b0;
    repeat (80) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
